// File: rtl/object_mover.sv
// -----------------------------------------------------------------------------
// object_mover
//   Per-frame motion controller for one on-screen object. Once per video frame
//   it updates the object's velocity from the move keys, gravity and latched
//   jump/floor events, integrates the position and clamps it to the screen.
//   Position and velocity are fixed point with FIXED_SHIFT fraction bits; the
//   drawer only ever sees whole pixels.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset (beats every other input)
//   startOfFrame  in   one-cycle pulse per video frame
//   enable        in   1 = motion updates allowed
//   moveLeft      in   level, sampled during the velocity update
//   moveRight     in   level, sampled during the velocity update
//   jumpReq       in   pulse, latched until the next velocity update
//   floorHit      in   pulse, latched until the next velocity update
//   topLeftX      out  signed 11-bit object position, pixels
//   topLeftY      out  signed 11-bit object position, pixels
//   airborne      out  1 = object is not resting on a floor
// -----------------------------------------------------------------------------
module object_mover #(
    parameter int INIT_X      = 280,
    parameter int INIT_Y      = 185,
    parameter int FIXED_SHIFT = 6,
    parameter int GRAVITY     = 16,
    parameter int MAX_VY      = 256,
    parameter int JUMP_VY     = -512,
    parameter int STEP_VX     = 128,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int OBJ_W       = 32,
    parameter int OBJ_H       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               moveLeft,
    input  logic               moveRight,
    input  logic               jumpReq,
    input  logic               floorHit,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               airborne
);

    // 18-bit signed fixed point leaves ample headroom: one frame of motion
    // can never push a position outside this range before the clamp.
    localparam logic signed [17:0] INIT_X_FP  = 18'(INIT_X << FIXED_SHIFT);
    localparam logic signed [17:0] INIT_Y_FP  = 18'(INIT_Y << FIXED_SHIFT);
    localparam logic signed [17:0] X_MAX_FP   = 18'((SCREEN_W - OBJ_W) << FIXED_SHIFT);
    localparam logic signed [17:0] Y_MAX_FP   = 18'((SCREEN_H - OBJ_H) << FIXED_SHIFT);
    localparam logic signed [17:0] GRAVITY_FP = 18'(GRAVITY);
    localparam logic signed [17:0] MAX_VY_FP  = 18'(MAX_VY);
    localparam logic signed [17:0] JUMP_VY_FP = 18'(JUMP_VY);
    localparam logic signed [17:0] STEP_VX_FP = 18'(STEP_VX);
    localparam logic signed [17:0] ZERO_FP    = 18'sd0;
    localparam logic signed [10:0] INIT_X_PX  = 11'(INIT_X);
    localparam logic signed [10:0] INIT_Y_PX  = 11'(INIT_Y);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_UPD_VEL = 2'd1,
        ST_UPD_POS = 2'd2,
        ST_CLAMP   = 2'd3
    } state_t;

    state_t              state_r;
    logic signed [17:0]  pos_x_r;
    logic signed [17:0]  pos_y_r;
    logic signed [17:0]  vx_r;
    logic signed [17:0]  vy_r;
    logic                airborne_r;
    logic                jump_l_r;
    logic                floor_l_r;
    logic signed [10:0]  top_left_x_r;
    logic signed [10:0]  top_left_y_r;

    logic signed [17:0]  vx_next_s;
    logic signed [17:0]  vy_floor_s;
    logic                air_floor_s;
    logic signed [17:0]  vy_grav_s;
    logic signed [17:0]  vy_next_s;
    logic                air_next_s;

    logic signed [17:0]  x_clamp_s;
    logic signed [17:0]  y_clamp_s;
    logic signed [17:0]  vy_clamp_s;
    logic                air_clamp_s;

    // Next velocity from keys and latched events; committed only in UPD_VEL.
    always_comb begin
        vx_next_s   = ZERO_FP;
        vy_floor_s  = vy_r;
        air_floor_s = airborne_r;
        vy_grav_s   = vy_r;
        vy_next_s   = vy_r;
        air_next_s  = airborne_r;

        case ({moveLeft, moveRight})
            2'b01:   vx_next_s = STEP_VX_FP;
            2'b10:   vx_next_s = -STEP_VX_FP;
            default: vx_next_s = ZERO_FP;
        endcase

        // A floor contact only lands the object when it is not moving upward.
        if (floor_l_r && (vy_r >= ZERO_FP)) begin
            vy_floor_s  = ZERO_FP;
            air_floor_s = 1'b0;
        end else begin
            vy_floor_s  = vy_r;
            air_floor_s = airborne_r;
        end

        vy_grav_s = vy_floor_s + GRAVITY_FP;

        // Jump is judged after landing, so floor+jump in one frame jumps.
        if (jump_l_r && !air_floor_s) begin
            vy_next_s  = JUMP_VY_FP;
            air_next_s = 1'b1;
        end else if (air_floor_s) begin
            vy_next_s  = (vy_grav_s > MAX_VY_FP) ? MAX_VY_FP : vy_grav_s;
            air_next_s = 1'b1;
        end else begin
            vy_next_s  = vy_floor_s;
            air_next_s = air_floor_s;
        end
    end

    // Screen clamp of the integrated position; committed only in CLAMP.
    always_comb begin
        x_clamp_s   = pos_x_r;
        y_clamp_s   = pos_y_r;
        vy_clamp_s  = vy_r;
        air_clamp_s = airborne_r;

        if (pos_x_r < ZERO_FP) begin
            x_clamp_s = ZERO_FP;
        end else if (pos_x_r > X_MAX_FP) begin
            x_clamp_s = X_MAX_FP;
        end else begin
            x_clamp_s = pos_x_r;
        end

        // Hitting the bottom edge acts as a floor; the top edge only stops upward motion.
        if (pos_y_r > Y_MAX_FP) begin
            y_clamp_s   = Y_MAX_FP;
            vy_clamp_s  = ZERO_FP;
            air_clamp_s = 1'b0;
        end else if (pos_y_r < ZERO_FP) begin
            y_clamp_s   = ZERO_FP;
            vy_clamp_s  = (vy_r < ZERO_FP) ? ZERO_FP : vy_r;
            air_clamp_s = airborne_r;
        end else begin
            y_clamp_s   = pos_y_r;
            vy_clamp_s  = vy_r;
            air_clamp_s = airborne_r;
        end
    end

    // Frame update FSM with event latches and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_WAIT;
            pos_x_r      <= INIT_X_FP;
            pos_y_r      <= INIT_Y_FP;
            vx_r         <= ZERO_FP;
            vy_r         <= ZERO_FP;
            airborne_r   <= 1'b1;
            jump_l_r     <= 1'b0;
            floor_l_r    <= 1'b0;
            top_left_x_r <= INIT_X_PX;
            top_left_y_r <= INIT_Y_PX;
        end else begin
            // Latches clear on leaving UPD_VEL, but a pulse in that very cycle survives.
            jump_l_r  <= jumpReq  | (jump_l_r  & (state_r != ST_UPD_VEL));
            floor_l_r <= floorHit | (floor_l_r & (state_r != ST_UPD_VEL));

            case (state_r)
                ST_WAIT: begin
                    if (startOfFrame && enable) begin
                        state_r <= ST_UPD_VEL;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_UPD_VEL: begin
                    vx_r       <= vx_next_s;
                    vy_r       <= vy_next_s;
                    airborne_r <= air_next_s;
                    state_r    <= ST_UPD_POS;
                end
                ST_UPD_POS: begin
                    pos_x_r <= pos_x_r + vx_r;
                    pos_y_r <= pos_y_r + vy_r;
                    state_r <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    pos_x_r      <= x_clamp_s;
                    pos_y_r      <= y_clamp_s;
                    vy_r         <= vy_clamp_s;
                    airborne_r   <= air_clamp_s;
                    top_left_x_r <= 11'(x_clamp_s >>> FIXED_SHIFT);
                    top_left_y_r <= 11'(y_clamp_s >>> FIXED_SHIFT);
                    state_r      <= ST_WAIT;
                end
                default: begin
                    state_r <= ST_WAIT;
                end
            endcase
        end
    end

    assign topLeftX = top_left_x_r;
    assign topLeftY = top_left_y_r;
    assign airborne = airborne_r;

endmodule

// File: tb/tb_object_mover.sv
// -----------------------------------------------------------------------------
// tb_object_mover
//   Scoreboard bench for object_mover. The driver pushes the expected pixel
//   position/airborne flag for every frame (from a frame-level model) and for
//   every probe (hand-computed constants). A monitor pops one entry four clock
//   edges after each startOfFrame or probe pulse and compares.
// -----------------------------------------------------------------------------
module tb_object_mover;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               enable = 1'b0;
    logic               moveLeft = 1'b0;
    logic               moveRight = 1'b0;
    logic               jumpReq = 1'b0;
    logic               floorHit = 1'b0;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               airborne;

    object_mover dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .moveLeft     (moveLeft),
        .moveRight    (moveRight),
        .jumpReq      (jumpReq),
        .floorHit     (floorHit),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .airborne     (airborne)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   x;
        int   y;
        logic air;
        int   id;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         seq_id = 0;
    logic [3:0] sof_pipe = 4'd0;
    logic       probe = 1'b0;

    // Frame-level reference state (fixed point, 6 fraction bits).
    int mpx, mpy, mvx, mvy;
    bit mair, mj, mf;

    // Outputs settle four edges after a startOfFrame (or probe) is sampled.
    always @(posedge clk) sof_pipe <= {sof_pipe[2:0], startOfFrame | probe};

    // Monitor: pop and compare whenever a result is due.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sof_pipe[3]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output due but no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if ($isunknown({topLeftX, topLeftY, airborne}) ||
                    int'(topLeftX) != e.x || int'(topLeftY) != e.y || airborne !== e.air) begin
                    errors++;
                    $display("FAIL entry_%0d: got x=%0d y=%0d air=%b, expected x=%0d y=%0d air=%b",
                             e.id, topLeftX, topLeftY, airborne, e.x, e.y, e.air);
                end
            end
        end
    end

    task automatic push_exp(input int x, input int y, input logic a);
        exp_t e;
        e.x = x; e.y = y; e.air = a; e.id = seq_id;
        seq_id++;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        mpx = 280 * 64; mpy = 185 * 64; mvx = 0; mvy = 0;
        mair = 1'b1; mj = 1'b0; mf = 1'b0;
    endtask

    task automatic model_update(input bit l, input bit r);
        if (r && !l)      mvx = 128;
        else if (l && !r) mvx = -128;
        else              mvx = 0;
        if (mf && mvy >= 0) begin mvy = 0; mair = 1'b0; end
        if (mj && !mair) begin
            mvy = -512; mair = 1'b1;
        end else if (mair) begin
            mvy = mvy + 16;
            if (mvy > 256) mvy = 256;
        end
        mj = 1'b0; mf = 1'b0;
        mpx = mpx + mvx; mpy = mpy + mvy;
        if (mpx < 0)       mpx = 0;
        if (mpx > 608 * 64) mpx = 608 * 64;
        if (mpy > 448 * 64) begin mpy = 448 * 64; mvy = 0; mair = 1'b0; end
        if (mpy < 0) begin mpy = 0; if (mvy < 0) mvy = 0; end
    endtask

    task automatic sync_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    // jmp_when: 0 none, 1 before the frame (WAIT), 2 during UPD_VEL, 3 during CLAMP.
    task automatic do_frame(input bit l, input bit r, input bit en, input int jmp_when, input bit flr);
        moveLeft = l; moveRight = r; enable = en;
        if (flr) mf = 1'b1;
        if (jmp_when == 1) mj = 1'b1;
        if (en) model_update(l, r);
        if (jmp_when == 2 || jmp_when == 3) mj = 1'b1;
        push_exp(mpx >>> 6, mpy >>> 6, mair);
        @(negedge clk); floorHit = flr; jumpReq = (jmp_when == 1);
        @(negedge clk); floorHit = 1'b0; jumpReq = 1'b0; startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0; jumpReq = (jmp_when == 2);
        @(negedge clk); jumpReq = 1'b0;
        @(negedge clk); jumpReq = (jmp_when == 3);
        @(negedge clk); jumpReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic probe_check(input int x, input int y, input logic a);
        push_exp(x, y, a);
        @(negedge clk); probe = 1'b1;
        @(negedge clk); probe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        model_reset();
        repeat (2) @(negedge clk);

        // 1: reset values, held without any frame pulse
        sync_reset();
        probe_check(280, 185, 1'b1);
        repeat (20) @(negedge clk);
        probe_check(280, 185, 1'b1);

        // 2: free fall from rest, vy = 16,32,48,64 -> +160fp -> Y 187
        for (int i = 0; i < 4; i++) do_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        probe_check(280, 187, 1'b1);

        // 3: move right 10 frames, then to saturation, both keys, then left edge
        sync_reset();
        for (int i = 0; i < 10; i++) do_frame(1'b0, 1'b1, 1'b1, 0, 1'b0);
        probe_check(300, 198, 1'b1);
        for (int i = 0; i < 190; i++) do_frame(1'b0, 1'b1, 1'b1, 0, 1'b0);
        probe_check(608, 448, 1'b0);
        for (int i = 0; i < 3; i++) do_frame(1'b1, 1'b1, 1'b1, 0, 1'b0);
        probe_check(608, 448, 1'b0);
        for (int i = 0; i < 320; i++) do_frame(1'b1, 1'b0, 1'b1, 0, 1'b0);
        probe_check(0, 448, 1'b0);

        // 4: land on floor, jump, floor ignored while rising, floor+jump together
        sync_reset();
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b1);
        probe_check(280, 185, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 1, 1'b0);
        probe_check(280, 177, 1'b1);
        do_frame(1'b0, 1'b0, 1'b1, 1, 1'b1);
        probe_check(280, 169, 1'b1);
        sync_reset();
        do_frame(1'b0, 1'b0, 1'b1, 1, 1'b1);
        probe_check(280, 177, 1'b1);

        // 5: fall to the bottom, disabled frame holds a latched jump
        sync_reset();
        for (int i = 0; i < 100; i++) do_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        probe_check(280, 448, 1'b0);
        do_frame(1'b0, 1'b0, 1'b0, 1, 1'b0);
        probe_check(280, 448, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        probe_check(280, 440, 1'b1);

        // 6: reset during UPD_POS aborts the update
        sync_reset();
        for (int i = 0; i < 2; i++) do_frame(1'b0, 1'b1, 1'b1, 0, 1'b0);
        push_exp(280, 185, 1'b1);
        @(negedge clk); moveRight = 1'b1; enable = 1'b1; startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; moveRight = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b1);
        probe_check(280, 185, 1'b0);
        // jump pulse in CLAMP is held for the following frame
        do_frame(1'b0, 1'b0, 1'b1, 3, 1'b0);
        probe_check(280, 185, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        probe_check(280, 177, 1'b1);
        // jump pulse in the same cycle as the latch clear is kept
        sync_reset();
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b1);
        do_frame(1'b0, 1'b0, 1'b1, 2, 1'b0);
        probe_check(280, 185, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        probe_check(280, 177, 1'b1);

        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
